// File: rtl/segment7_scanner.sv
// Time-multiplexed 7-segment scan controller: drives one shared decoder a nibble at a time,
// registers the decoded pattern and sequences the anodes with an all-off guard interval.
module segment7_scanner #(
  parameter int DIGITS  = 4,
  parameter int ON_CYC  = 50000,
  parameter int GAP_CYC = 500
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic                  LOAD,
  input  logic                  LZS,
  input  logic [DIGITS-1:0]     DP,
  output logic [3:0]            DEC_IN,
  input  logic [7:0]            DEC_OUT,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  FRAME
);

  localparam int CNT_MAX = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(DIGITS);

  typedef enum logic [1:0] {SETUP, SHOW, GAP} state_t;

  state_t              state, state_next;
  logic [IW-1:0]       idx, idx_next, idx_inc;
  logic [CW-1:0]       cnt, cnt_next;
  logic [4*DIGITS-1:0] shadow, active, active_next;
  logic [DIGITS-1:0]   upper_zero;
  logic                boundary;
  logic                entering_setup;
  logic                blank;

  assign idx_inc = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    unique case (state)
      SETUP: begin
        state_next = SHOW;
        cnt_next   = '0;
      end
      SHOW: begin
        if (cnt == CW'(ON_CYC - 1)) begin
          cnt_next = '0;
          if (GAP_CYC == 0) begin
            state_next = SETUP;
            idx_next   = idx_inc;
          end else begin
            state_next = GAP;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYC - 1)) begin
          cnt_next   = '0;
          state_next = SETUP;
          idx_next   = idx_inc;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = SETUP;
    endcase
  end

  // The frame boundary is the edge into SETUP of digit 0; a LOAD on that very edge bypasses shadow.
  assign entering_setup = (state != SETUP) && (state_next == SETUP);
  assign boundary       = entering_setup && (idx_next == '0);
  assign active_next    = boundary ? (LOAD ? VALUE : shadow) : active;

  // upper_zero[k]: every nibble from the top digit down to digit k is zero.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_upper
      assign upper_zero[gi] = (active[4*DIGITS-1:4*gi] == '0);
    end
  endgenerate

  assign blank = LZS && (idx != '0) && upper_zero[idx];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= SETUP;
      idx    <= '0;
      cnt    <= '0;
      shadow <= '0;
      active <= '0;
      DEC_IN <= '0;
      SEG    <= 8'hFF;
      AN     <= '1;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      cnt    <= cnt_next;
      active <= active_next;
      if (LOAD)
        shadow <= VALUE;
      if (entering_setup)
        DEC_IN <= active_next[4*idx_next +: 4];
      if (state == SETUP)
        SEG <= blank ? 8'hFF : {DEC_OUT[7] & ~DP[idx], DEC_OUT[6:0]};
      AN <= (state_next == SHOW) ? ~(DIGITS'(1) << idx_next) : '1;
    end
  end

  assign FRAME = (state == SETUP) && (idx == '0) && !RST;

endmodule

// File: tb/tb_segment7_scanner.sv
// Bench for segment7_scanner: two instances (with and without a gap state) checked each cycle
// against a time-arithmetic reference model, plus a segment-pattern table and corner sequences.
module tb_segment7_scanner;
  localparam int DIGITS = 4;
  localparam int ON     = 4;

  logic        clk = 1'b0;
  logic        rst, load, lzs;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  dec_in_a, dec_in_b, an_a, an_b;
  logic [7:0]  dec_out_a, dec_out_b, seg_a, seg_b;
  logic        frame_a, frame_b;

  always #5 clk = ~clk;

  // Reference decoder: active-low hex font; the DP bit is lit only for nibble F.
  function automatic logic [7:0] decode(input logic [3:0] n);
    logic [6:0] lit;
    case (n)
      4'h0: lit = 7'h3F; 4'h1: lit = 7'h06; 4'h2: lit = 7'h5B; 4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66; 4'h5: lit = 7'h6D; 4'h6: lit = 7'h7D; 4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F; 4'h9: lit = 7'h6F; 4'hA: lit = 7'h77; 4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39; 4'hD: lit = 7'h5E; 4'hE: lit = 7'h79; default: lit = 7'h71;
    endcase
    return {n != 4'hF, ~lit};
  endfunction

  assign dec_out_a = decode(dec_in_a);
  assign dec_out_b = decode(dec_in_b);

  segment7_scanner #(.DIGITS(DIGITS), .ON_CYC(ON), .GAP_CYC(1)) dut_a (
    .CLK(clk), .RST(rst), .VALUE(value), .LOAD(load), .LZS(lzs), .DP(dp),
    .DEC_IN(dec_in_a), .DEC_OUT(dec_out_a), .SEG(seg_a), .AN(an_a), .FRAME(frame_a));

  segment7_scanner #(.DIGITS(DIGITS), .ON_CYC(ON), .GAP_CYC(0)) dut_b (
    .CLK(clk), .RST(rst), .VALUE(value), .LOAD(load), .LZS(lzs), .DP(dp),
    .DEC_IN(dec_in_b), .DEC_OUT(dec_out_b), .SEG(seg_b), .AN(an_b), .FRAME(frame_b));

  int errors = 0;
  int checks = 0;

  // Model: t counts cycles since reset; digit and phase follow from the period.
  int          t   [2];
  int          per [2] = '{6, 5};
  logic [15:0] sh  [2];
  logic [15:0] act [2];
  logic [7:0]  sexp[2];
  logic        checking = 1'b0;
  logic        cap_on   = 1'b0;
  logic [31:0] cur_exp;

  logic [3:0] s_an[2], s_di[2];
  logic [7:0] s_seg[2];
  logic       s_fr[2];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rule_seg(input logic [15:0] a, input int d,
                                           input logic z, input logic [3:0] p);
    logic [7:0] raw;
    if (z && d != 0 && (a >> (4*d)) == 16'h0)
      return 8'hFF;
    raw = decode(4'(a >> (4*d)));
    return {raw[7] & ~p[d], raw[6:0]};
  endfunction

  task automatic step();
    int ph, d;
    string nm;
    logic [3:0] e_an, e_di;
    logic       e_fr;
    @(negedge clk);
    s_an[0] = an_a;   s_an[1] = an_b;
    s_di[0] = dec_in_a; s_di[1] = dec_in_b;
    s_seg[0] = seg_a; s_seg[1] = seg_b;
    s_fr[0] = frame_a; s_fr[1] = frame_b;
    for (int k = 0; k < 2; k++) begin
      if (checking) begin
        ph   = t[k] % per[k];
        d    = (t[k] / per[k]) % DIGITS;
        nm   = (k == 0) ? "a" : "b";
        e_an = (ph >= 1 && ph <= ON) ? ~(4'b0001 << d) : 4'hF;
        e_di = 4'(act[k] >> (4*d));
        e_fr = (ph == 0 && d == 0 && !rst);
        check({"an_", nm}, s_an[k], e_an);
        check({"dec_in_", nm}, s_di[k], e_di);
        check({"seg_", nm}, s_seg[k], sexp[k]);
        check({"frame_", nm}, s_fr[k], e_fr);
        if (cap_on && k == 0 && ph == 1)
          check("tbl_seg", s_seg[0], cur_exp[8*d +: 8]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        t[k] = 0; sh[k] = '0; act[k] = '0; sexp[k] = 8'hFF;
      end else begin
        if (t[k] % per[k] == 0)
          sexp[k] = rule_seg(act[k], (t[k] / per[k]) % DIGITS, lzs, dp);
        t[k]++;
        if (t[k] % (per[k] * DIGITS) == 0)
          act[k] = load ? value : sh[k];
        if (load)
          sh[k] = value;
      end
    end
    checking = 1'b1;
    #1;
  endtask

  task automatic run_to(input int k, input int modv, input int target);
    for (int i = 0; i < 64; i++) begin
      if (t[k] % modv == target) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL run_to: got no phase %0d of %0d on instance %0d", target, modv, k);
  endtask

  typedef struct {
    logic [15:0] value;
    logic        lzs;
    logic [3:0]  dp;
    logic [31:0] seg;   // digit 3 .. digit 0 patterns
  } vec_t;

  initial begin
    vec_t       vecs[7];
    logic [3:0] an_seq[4];
    logic [15:0] v;

    vecs[0] = '{16'h0050, 1'b1, 4'b0000, 32'hFFFF_92C0};
    vecs[1] = '{16'h0000, 1'b1, 4'b0000, 32'hFFFF_FFC0};
    vecs[2] = '{16'h9876, 1'b0, 4'b0100, 32'h9000_F882};
    vecs[3] = '{16'h0F01, 1'b1, 4'b0001, 32'hFF0E_C079};
    vecs[4] = '{16'h3000, 1'b1, 4'b1000, 32'h30C0_C0C0};
    vecs[5] = '{16'h0000, 1'b0, 4'b1111, 32'h4040_4040};
    vecs[6] = '{16'h0A00, 1'b1, 4'b1000, 32'hFF88_C0C0};
    an_seq  = '{4'hE, 4'hD, 4'hB, 4'h7};

    rst = 1'b1; load = 1'b0; lzs = 1'b0; dp = '0; value = '0;
    repeat (3) step();
    check("rst_seg", s_seg[0], 8'hFF);
    check("rst_an", {4'h0, s_an[0]}, 8'h0F);

    // Release: FRAME in cycle 0, anode 0 low for cycles 1-4.
    rst = 1'b0;
    step();
    check("rel_frame", {7'h0, s_fr[0]}, 8'h01);
    check("rel_an0", {4'h0, s_an[0]}, 8'h0F);
    step();
    check("rel_an1", {4'h0, s_an[0]}, 8'h0E);
    check("rel_seg1", s_seg[0], 8'hC0);

    // LOAD mid-frame shows up only in the following frame.
    run_to(0, 24, 8);
    value = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    run_to(0, 24, 0);
    for (int d = 0; d < 4; d++) begin
      step();
      check("scan_dec_in", {4'h0, s_di[0]}, 8'(4 - d));
      step();
      check("scan_an", {4'h0, s_an[0]}, {4'h0, an_seq[d]});
      repeat (4) step();
    end

    // Segment table: blanking and decimal-point rules.
    foreach (vecs[i]) begin
      lzs = vecs[i].lzs; dp = vecs[i].dp; value = vecs[i].value; load = 1'b1;
      step();
      load = 1'b0;
      run_to(0, 24, 0);
      cur_exp = vecs[i].seg;
      cap_on  = 1'b1;
      repeat (24) step();
      cap_on  = 1'b0;
    end

    // Reset in the 2nd SHOW cycle of digit 2.
    run_to(0, 24, 14);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("mid_rst_an", {4'h0, s_an[0]}, 8'h0F);
    check("mid_rst_seg", s_seg[0], 8'hFF);
    check("mid_rst_frame", {7'h0, s_fr[0]}, 8'h01);
    check("mid_rst_dec_in", {4'h0, s_di[0]}, 8'h00);

    // No-gap instance: LOAD exactly on the boundary cycle is bypassed into digit 0.
    run_to(1, 20, 19);
    v = 16'hBEE7;
    value = v; load = 1'b1;
    step();
    load = 1'b0;
    step();
    check("bypass_dec_in", {4'h0, s_di[1]}, {4'h0, v[3:0]});
    check("bypass_frame", {7'h0, s_fr[1]}, 8'h01);
    step();
    check("bypass_an", {4'h0, s_an[1]}, 8'h0E);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
      load  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) lzs = 1'($urandom);
      if ($urandom_range(0, 9) == 0) dp  = 4'($urandom);
      rst   = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/segment7_scanner.md
# segment7_scanner

Time-multiplexed scan controller for a multi-digit 7-segment display. It owns a single shared `Decoder` instance (4-bit `IN` to 8-bit `OUT`) and presents one digit's nibble to it at a time. It registers the decoded pattern and drives the digit-enable lines with an anode-off guard interval, so digits do not ghost. It sits between the value-producing logic (counters, register readback) and the board segment/anode pins.

## Interface
- `DIGITS`, 4: number of digits scanned (2..8).
- `ON_CYC`, 50000: clock cycles a digit is enabled per visit (≥1).
- `GAP_CYC`, 500: all-anodes-off cycles after each digit (≥0; 0 removes the GAP state).
- `CLK`  in  1  system clock; one clock domain.
- `RST`  in  1  synchronous, active-high reset.
- `VALUE`  in  4*DIGITS  digit nibbles; `VALUE[3:0]` is digit 0, the least significant digit.
- `LOAD`  in  1  one-cycle strobe that captures `VALUE` into the shadow register.
- `LZS`  in  1  leading-zero suppression enable; level, sampled each SETUP.
- `DP`  in  DIGITS  decimal-point request per digit; level.
- `DEC_IN`  out  4  registered nibble driven to the decoder's `IN`.
- `DEC_OUT`  in  8  decoder `OUT`; active-low segments, bit 7 = DP, bits 6:0 = g..a.
- `SEG`  out  8  registered segment pins, active-low; same bit order as `DEC_OUT`.
- `AN`  out  DIGITS  digit enables, active-low, at most one low at a time.
- `FRAME`  out  1  one-cycle pulse during SETUP of digit 0.

## Operation
- Registers: `shadow` and `active` (4*DIGITS each), digit index `idx`, state, cycle counter.
- `LOAD=1` sets `shadow <= VALUE` in that cycle.
- `active` updates only at the frame boundary, on the edge into SETUP of digit 0: `active <= LOAD ? VALUE : shadow`. This prevents tearing.
- FSM states: SETUP → SHOW → GAP → SETUP.
- SETUP (1 cycle):
  - `AN` is all ones.
  - `DEC_IN` holds `active[4*idx+3:4*idx]`.
  - On exit, `SEG` captures the pattern for the current digit (see segment rules below).
- SHOW (`ON_CYC` cycles):
  - `AN[idx]=0` and `SEG` is held.
  - After the last cycle, go to GAP. If `GAP_CYC=0`, advance `idx` and go to SETUP.
- GAP (`GAP_CYC` cycles):
  - `AN` is all ones and `SEG` is held.
  - After the last cycle, advance `idx` and go to SETUP.
- `idx` advances 0,1,…,DIGITS-1 and wraps to 0.
- Segment rules on SETUP exit:
  - Blanked digit: `SEG = 8'hFF`, including DP.
  - Otherwise: `SEG = {DEC_OUT[7] & ~DP[idx], DEC_OUT[6:0]}`.
- Blanking rule:
  - Digit k is blanked when `LZS=1`, k ≠ 0, and all nibbles of `active` from digit DIGITS-1 down to digit k are zero.
  - Digit 0 is never blanked.
  - A blanked digit still gets its SHOW slot, with `AN` low and `SEG=FF`.
- The decoder is combinational. `DEC_OUT` is consumed only in SETUP, one cycle after `DEC_IN` changes.

## Timing
- Reset values (next edge with `RST=1`):
  - `SEG=8'hFF`, `AN` all ones, `DEC_IN=0`, `FRAME=0`.
  - `idx=0`, `shadow=0`, `active=0`, state SETUP.
- First cycle after `RST` deasserts: SETUP of digit 0 with `FRAME=1`.
- Reset mid-operation overrides everything: the next cycle shows the reset values. A `LOAD` in the same cycle as `RST` is ignored.
- Digit period is `1+ON_CYC+GAP_CYC` cycles; frame period is `DIGITS` times that.
- `LOAD` latency to display:
  - `LOAD` before the boundary edge: the new value is shown in the next frame.
  - `LOAD` on the boundary cycle: bypassed into `active` in the same edge.
- `DEC_IN` in SETUP of digit 0 reflects the `active` value loaded at that same edge.
- `LZS` and `DP` changes take effect at the next SETUP; no glitch inside SHOW.
- Two `LOAD`s within one frame: the last one wins.

## Test plan
All scenarios use `DIGITS=4`, `ON_CYC=4`, `GAP_CYC=1` unless stated, giving a 6-cycle digit period and a 24-cycle frame.

1. Hold `RST=1` for 3 cycles → `SEG=FF`, `AN=1111`. Release → `FRAME=1` on cycle 0; `AN` low in cycles 1–4 only, at bit 0; `SEG=DEC_OUT` for digit 0 (value 0).
2. `LOAD` `VALUE=16'h1234` at cycle 8 of a frame → the current frame is unchanged. The next frame gives `DEC_IN` sequence 4,3,2,1 in SETUPs, with `AN` = 1110, 1101, 1011, 0111 in the SHOW slots.
3. `LZS=1`:
   - `VALUE=16'h0050` → digits 3 and 2 show `SEG=FF`; digit 1 shows the "5" pattern; digit 0 shows the "0" pattern.
   - `VALUE=0` → only digit 0 shows a lit pattern.
4. `DP=4'b0100`, `VALUE=16'h9876` → `SEG[7]=0` only during digit 2 SHOW/GAP. All other digits have `SEG[7]=DEC_OUT[7]`.
5. Assert `RST` in the 2nd SHOW cycle of digit 2 → next cycle `AN=1111`, `SEG=FF`, `active=0`. The restart begins at digit 0 with `FRAME=1`.
6. Set `GAP_CYC=0` → digit period is 5 cycles, with no all-off cycle other than SETUP. `LOAD` exactly on the boundary cycle → the new value appears in `DEC_IN` immediately, for digit 0.
